// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared board constants, FSM state encoding and board cell layout
package sudoku_pkg;
  localparam int CELLS = 81;
  localparam int NUM_MAPS = 15;
  localparam int DIGIT_W = 4;
  localparam int CELL_W = 7;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2, DONE = 2'd3} state_e;
  typedef struct packed {
    logic [DIGIT_W-1:0] sol;
    logic [DIGIT_W-1:0] dig;
    logic               fix;
  } cell_t;
endpackage

// File: rtl/board_ram.sv
// board_ram: 81-cell {solution, digit, fixed} store, one sync write port, two comb read ports
module board_ram
  import sudoku_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [CELL_W-1:0]    wa,
  input  logic [2*DIGIT_W:0]   wd,
  input  logic [CELL_W-1:0]    ra,
  output logic [2*DIGIT_W:0]   ra_q,
  input  logic [CELL_W-1:0]    rb,
  output logic [DIGIT_W-1:0]   rb_dig,
  output logic                 rb_fix
);
  localparam logic [CELL_W-1:0] FULL = CELL_W'(CELLS);
  logic [2*DIGIT_W:0] mem_q [CELLS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < CELLS; i++) mem_q[i] <= '0;
    else if (we && wa < FULL) mem_q[wa] <= wd;
  always_comb begin
    ra_q = ra < FULL ? mem_q[ra] : '0;
    rb_dig = rb < FULL ? mem_q[rb][DIGIT_W:1] : '0;
    rb_fix = rb < FULL ? mem_q[rb][0] : 1'b0;
  end
endmodule

// File: rtl/puzzle_controller.sv
// puzzle_controller: sudoku game FSM over a 9x9 board; define MISTAKE_COUNT_EN for the 3-strike failure path
module puzzle_controller #(
  parameter int NUM_MAPS = 15,
  parameter int CELLS = 81
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] map_sel,
  output logic [3:0] map_idx,
  output logic [6:0] map_cell,
  input  logic [3:0] map_digit,
  input  logic       map_vis,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [6:0] move_cell,
  input  logic [3:0] move_digit,
  output logic       move_ack,
  output logic       move_ok,
  input  logic [6:0] rd_cell,
  output logic [3:0] rd_digit,
  output logic       rd_fixed,
  output logic [1:0] state,
  output logic [6:0] filled_cnt,
  output logic       solved,
  output logic [1:0] mistakes
);
  import sudoku_pkg::state_e;
  import sudoku_pkg::cell_t;
  import sudoku_pkg::IDLE;
  import sudoku_pkg::LOAD;
  import sudoku_pkg::PLAY;
  import sudoku_pkg::DONE;
  localparam logic [6:0] LAST = 7'(CELLS - 1);
  localparam logic [6:0] FULL = 7'(CELLS);
  state_e state_q, state_d;
  logic [3:0] map_idx_q, map_idx_d;
  logic [6:0] cell_q, cell_d, filled_q, filled_d, correct_q, correct_d, wa;
  logic [1:0] mis_q, mis_d;
  logic ack_q, ack_d, ok_q, ok_d;
  logic acc, good, load_we, we, old_f, new_f, old_c, new_c;
  cell_t mv, wd;
  board_ram u_ram (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra(move_cell), .ra_q(mv), .rb(rd_cell), .rb_dig(rd_digit), .rb_fix(rd_fixed)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = start ? LOAD
            : state_q == LOAD ? (cell_q == LAST ? PLAY : LOAD)
            : state_q == PLAY && (correct_d == FULL || mis_d == 2'd3) ? DONE
            : state_q;
  always_comb begin
    move_ready = state_q == PLAY && !start;
    state = state_q;
    map_idx = map_idx_q;
    map_cell = cell_q;
    move_ack = ack_q;
    move_ok = ok_q;
    filled_cnt = filled_q;
    solved = correct_q == FULL;
    mistakes = mis_q;
  end
  always_comb begin
    acc = move_valid && move_ready;
    good = acc && move_cell < FULL && move_digit <= 4'd9 && !mv.fix;
    load_we = state_q == LOAD && !start;
    we = load_we || good;
    wa = load_we ? cell_q : move_cell;
    wd = load_we ? {map_digit, map_vis ? map_digit : 4'd0, map_vis} : {mv.sol, move_digit, 1'b0};
    old_f = mv.dig != 4'd0;
    new_f = move_digit != 4'd0;
    old_c = mv.dig == mv.sol;
    new_c = move_digit == mv.sol;
    map_idx_d = start ? (int'(map_sel) < NUM_MAPS ? map_sel : 4'd0) : map_idx_q;
    cell_d = start ? 7'd0 : load_we ? (cell_q == LAST ? 7'd0 : cell_q + 7'd1) : cell_q;
    filled_d = start ? 7'd0 : load_we ? filled_q + 7'(map_vis)
             : good ? filled_q + 7'(new_f) - 7'(old_f) : filled_q;
    correct_d = start ? 7'd0 : load_we ? correct_q + 7'(map_vis)
              : good ? correct_q + 7'(new_c) - 7'(old_c) : correct_q;
`ifdef MISTAKE_COUNT_EN
    mis_d = start ? 2'd0 : good && new_f && !new_c && mis_q != 2'd3 ? mis_q + 2'd1 : mis_q;
`else
    mis_d = 2'd0;
`endif
    ack_d = acc;
    ok_d = good;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      map_idx_q <= '0;
      cell_q <= '0;
      filled_q <= '0;
      correct_q <= '0;
      mis_q <= '0;
      ack_q <= 1'b0;
      ok_q <= 1'b0;
    end else begin
      map_idx_q <= map_idx_d;
      cell_q <= cell_d;
      filled_q <= filled_d;
      correct_q <= correct_d;
      mis_q <= mis_d;
      ack_q <= ack_d;
      ok_q <= ok_d;
    end
endmodule

// File: tb/tb_puzzle_controller.sv
// tb_puzzle_controller: randomized game play against a board-level reference model
module tb_puzzle_controller;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, move_valid = 1'b0;
  logic [3:0] map_sel, map_idx, map_digit, move_digit, rd_digit;
  logic [6:0] map_cell, move_cell, rd_cell, filled_cnt;
  logic map_vis, move_ready, move_ack, move_ok, rd_fixed, solved;
  logic [1:0] state, mistakes;
  int vecs = 0, errs = 0, seed = 0;
  int m_sol [81];
  int m_dig [81];
  bit m_fix [81];
  int ms = 0, m_mis = 0;
  puzzle_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .map_sel(map_sel), .map_idx(map_idx),
    .map_cell(map_cell), .map_digit(map_digit), .map_vis(map_vis), .move_valid(move_valid),
    .move_ready(move_ready), .move_cell(move_cell), .move_digit(move_digit), .move_ack(move_ack),
    .move_ok(move_ok), .rd_cell(rd_cell), .rd_digit(rd_digit), .rd_fixed(rd_fixed),
    .state(state), .filled_cnt(filled_cnt), .solved(solved), .mistakes(mistakes)
  );
  always #5 clk = ~clk;
  function automatic int sol_of(input int m, input int c);
    return ((c / 9) * 3 + (c / 9) / 3 + c % 9 + m) % 9 + 1;
  endfunction
  function automatic bit vis_of(input int m, input int c, input int s);
    return c == 0 || ((c * 37 + m * 11 + s) % 5) < 2;
  endfunction
  assign map_digit = 4'(sol_of(int'(map_idx), int'(map_cell)));
  assign map_vis = vis_of(int'(map_idx), int'(map_cell), seed);
  function automatic int filled_m();
    int n = 0;
    for (int c = 0; c < 81; c++) if (m_dig[c] != 0) n++;
    return n;
  endfunction
  function automatic bit solved_m();
    for (int c = 0; c < 81; c++) if (m_dig[c] != m_sol[c]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_status();
    chk("state", int'(state), ms);
    chk("filled_cnt", int'(filled_cnt), filled_m());
    chk("solved", int'(solved), int'(solved_m()));
    chk("mistakes", int'(mistakes), m_mis);
  endtask
  task automatic load_game(input int sel, input int abort_at, input int sel2);
    int s = sel;
    int m;
    start = 1'b1;
    map_sel = 4'(sel);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 81; i++) begin
      if (i == 0) chk("map_idx", int'(map_idx), s < 15 ? s : 0);
      chk("load_cell", int'(map_cell), i);
      chk("load_state", int'(state), 1);
      if (i == abort_at) begin
        start = 1'b1;
        map_sel = 4'(sel2);
        s = sel2;
        abort_at = -1;
        i = -1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    m = s < 15 ? s : 0;
    for (int c = 0; c < 81; c++) begin
      m_sol[c] = sol_of(m, c);
      m_fix[c] = vis_of(m, c, seed);
      m_dig[c] = m_fix[c] ? m_sol[c] : 0;
    end
    ms = 2;
    m_mis = 0;
    check_status();
  endtask
  task automatic move(input int c, input int d);
    bit acc, ok;
    int rc;
    acc = ms == 2;
    ok = acc && c < 81 && d <= 9 && !(c < 81 && m_fix[c]);
    chk("move_ready", int'(move_ready), int'(acc));
    move_valid = 1'b1;
    move_cell = 7'(c);
    move_digit = 4'(d);
    @(negedge clk);
    if (ok) begin
`ifdef MISTAKE_COUNT_EN
      if (d != 0 && d != m_sol[c] && m_mis < 3) m_mis++;
`endif
      m_dig[c] = d;
      if (m_mis == 3 || solved_m()) ms = 3;
    end
    chk("move_ack", int'(move_ack), int'(acc));
    chk("move_ok", int'(move_ok), int'(ok));
    check_status();
    rc = c < 81 ? c : 0;
    rd_cell = 7'(rc);
    #1;
    chk("rd_digit", int'(rd_digit), m_dig[rc]);
    chk("rd_fixed", int'(rd_fixed), int'(m_fix[rc]));
  endtask
  function automatic int empty_cell(input int nth);
    for (int c = 0; c < 81; c++) if (!m_fix[c] && m_dig[c] == 0) begin
      if (nth == 0) return c;
      nth--;
    end
    return 0;
  endfunction
  initial begin
    int e;
    seed = int'($urandom_range(0, 999));
    map_sel = '0;
    move_cell = '0;
    move_digit = '0;
    rd_cell = 7'd37;
    for (int c = 0; c < 81; c++) begin
      m_sol[c] = 0;
      m_dig[c] = 0;
      m_fix[c] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_map_idx", int'(map_idx), 0);
    chk("rst_map_cell", int'(map_cell), 0);
    chk("rst_ack", int'(move_ack), 0);
    chk("rst_ok", int'(move_ok), 0);
    chk("rst_filled", int'(filled_cnt), 0);
    chk("rst_solved", int'(solved), 0);
    chk("rst_mistakes", int'(mistakes), 0);
    chk("rst_rd_digit", int'(rd_digit), 0);
    chk("rst_rd_fixed", int'(rd_fixed), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", int'(state), 0);
    load_game(2, -1, 0);
    move(0, 5);
    move(90, 3);
    e = empty_cell(0);
    move(e, 12);
    move(e, m_sol[e]);
    move(e, 0);
    repeat (40) move(int'($urandom_range(0, 100)), int'($urandom_range(0, 11)));
    move_valid = 1'b0;
    @(negedge clk);
    chk("ack_idle", int'(move_ack), 0);
    load_game(15, 40, 7);
    for (int c = 0; c < 81; c++) if (m_dig[c] != m_sol[c]) move(c, m_sol[c]);
    move_valid = 1'b0;
    @(negedge clk);
    chk("done_ready", int'(move_ready), 0);
    chk("done_state", int'(state), 3);
    chk("done_solved", int'(solved), 1);
    load_game(3, -1, 0);
    e = empty_cell(0);
    start = 1'b1;
    map_sel = 4'd3;
    move_valid = 1'b1;
    move_cell = 7'(e);
    move_digit = 4'(m_sol[e]);
    #1;
    chk("ready_vs_start", int'(move_ready), 0);
    @(negedge clk);
    start = 1'b0;
    move_valid = 1'b0;
    chk("start_wins_ack", int'(move_ack), 0);
    chk("start_wins_state", int'(state), 1);
    chk("start_wins_cell", int'(map_cell), 0);
    load_game(3, -1, 0);
    for (int k = 0; k < 3; k++) begin
      e = empty_cell(0);
      move(e, m_sol[e] % 9 + 1);
    end
    move(empty_cell(0), 0);
    move_valid = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/puzzle_controller.md
PUZZLE_CONTROLLER -- requirements
Module: puzzle_controller

Interface
REQ-001 Parameter NUM_MAPS, default 15: number of stored puzzles.
REQ-002 Parameter CELLS, default 81: cells per board (9x9).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  pulse: begin new game with map_sel.
REQ-006 map_sel  in  4  requested puzzle index.
REQ-007 map_idx  out  4  puzzle index presented to the map store.
REQ-008 map_cell  out  7  cell address presented to the map store.
REQ-009 map_digit  in  4  solution digit (1..9) for map_idx/map_cell, combinational.
REQ-010 map_vis  in  1  1 = cell is a given (visible, fixed).
REQ-011 move_valid  in  1  player move request.
REQ-012 move_ready  out  1  move can be accepted this cycle.
REQ-013 move_cell  in  7  target cell 0..80, row-major.
REQ-014 move_digit  in  4  0 = clear, 1..9 = enter.
REQ-015 move_ack  out  1  one-cycle pulse, move processed.
REQ-016 move_ok  out  1  qualifies move_ack: 1 = applied, 0 = rejected.
REQ-017 rd_cell  in  7  display read address.
REQ-018 rd_digit  out  4  current digit at rd_cell (0 = empty), combinational.
REQ-019 rd_fixed  out  1  rd_cell is a given.
REQ-020 state  out  2  IDLE=0, LOAD=1, PLAY=2, DONE=3.
REQ-021 filled_cnt  out  7  non-empty cells.
REQ-022 solved  out  1  board complete and correct.
REQ-023 mistakes  out  2  wrong entries (see Configuration).

Function
REQ-024 FSM IDLE->LOAD on start; LOAD->PLAY after last cell; PLAY->DONE when solved; start in any state ->LOAD next cycle.
REQ-025 On entry to LOAD, map_idx latches map_sel; map_sel >= NUM_MAPS latches 0.
REQ-026 LOAD walks map_cell 0..80, one cell per cycle, 81 cycles exactly; each cycle stores solution=map_digit, fixed=map_vis, digit=map_vis ? map_digit : 0.
REQ-027 start during LOAD restarts at cell 0 with newly latched map_idx.
REQ-028 filled_cnt and correct count rebuilt during LOAD; final values valid first PLAY cycle.
REQ-029 move_ready = (state==PLAY) & ~start; handshake on move_valid & move_ready.
REQ-030 Accepted move: board updated end of cycle; move_ack pulses next cycle with move_ok.
REQ-031 Rejected (move_ok=0, board unchanged): move_cell>80, move_digit>9, fixed cell.
REQ-032 filled_cnt: +1 on empty->nonzero, -1 on nonzero->0, unchanged on nonzero->nonzero; range 0..81.
REQ-033 solved=1 when correct count reaches 81; state goes DONE same edge the last correct move is written.
REQ-034 start and move_valid same cycle: start wins, move not accepted, no ack.
REQ-035 Back-to-back moves accepted every cycle in PLAY.

Reset
REQ-036 rst_n low: state=IDLE, map_idx=0, map_cell=0, move_ack=0, move_ok=0, filled_cnt=0, solved=0, mistakes=0, board storage all 0 / non-fixed.

Configuration
REQ-037 MISTAKE_COUNT_EN defined: accepted nonzero move_digit != solution increments mistakes (saturating 3); reaching 3 forces DONE with solved=0; reset to 0 on LOAD.
REQ-038 MISTAKE_COUNT_EN undefined: mistakes tied 0, no failure path.

Structure
REQ-039 Package sudoku_pkg: CELLS, NUM_MAPS, DIGIT_W=4, CELL_W=7, state enum.
REQ-040 Sub-module board_ram: 81 entries of {solution, digit, fixed}, one synchronous write port, two combinational read ports (move path, display path).

Verification
REQ-041 Reset, start with map_sel=2 -> state LOAD 81 cycles, map_cell 0..80, then PLAY; filled_cnt = given count of map 2.
REQ-042 Move to fixed cell 0 (given) -> move_ack=1, move_ok=0, rd_digit unchanged.
REQ-043 Enter correct digit in empty cell, then digit 0 -> filled_cnt +1 then -1, both move_ok=1.
REQ-044 Fill all empty cells with solution -> solved=1, state=DONE on final write, move_ready=0.
REQ-045 map_sel=15 -> map_idx=0; start asserted mid-LOAD at cell 40 -> reload from cell 0.
REQ-046 MISTAKE_COUNT_EN: three wrong digits -> mistakes=3, state=DONE, solved=0; without macro mistakes stays 0.
